// File: rtl/pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ctrl
//  Function : Sequencing controller for the PWM output comparator. Keeps a
//             shadow configuration, applies it to the active set on a period
//             boundary (or at once while stopped), runs the prescaled period
//             counter and drives the comparator enable.
//  Options  : PWM_CTRL_ONESHOT_EN - adds a mode register (address 5, bit 0)
//             selecting one-shot operation that ends with 'done'.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_ctrl #(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [CNT_W-1:0]   cfg_wdata,
    input  logic               commit,
    output logic [CNT_W-1:0]   period_o,
    output logic [CNT_W-1:0]   compare1_o,
    output logic [CNT_W-1:0]   compare2_o,
    output logic [7:0]         functions_o,
    output logic [CNT_W-1:0]   count_val,
    output logic               pwm_en_o,
    output logic               period_tick,
    output logic               commit_pending,
    output logic               done
);

    localparam logic [2:0]         C_ADDR_PERIOD = 3'd0;
    localparam logic [2:0]         C_ADDR_CMP1   = 3'd1;
    localparam logic [2:0]         C_ADDR_CMP2   = 3'd2;
    localparam logic [2:0]         C_ADDR_FUNC   = 3'd3;
    localparam logic [2:0]         C_ADDR_PRESC  = 3'd4;
    localparam logic [CNT_W-1:0]   C_CNT_ONE     = 1;
    localparam logic [PRESC_W-1:0] C_PRESC_ONE   = 1;

    // Shadow set (written by the host, invisible to the comparator)
    logic [CNT_W-1:0]   r_sh_period;
    logic [CNT_W-1:0]   r_sh_cmp1;
    logic [CNT_W-1:0]   r_sh_cmp2;
    logic [7:0]         r_sh_func;
    logic [PRESC_W-1:0] r_sh_presc;

    // Active set (what the comparator and counter use)
    logic [CNT_W-1:0]   r_act_period;
    logic [CNT_W-1:0]   r_act_cmp1;
    logic [CNT_W-1:0]   r_act_cmp2;
    logic [7:0]         r_act_func;
    logic [PRESC_W-1:0] r_act_presc;

    // Counter and sequencing state
    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_count;
    logic               r_period_tick;
    logic               r_pending;
    logic               r_pwm_en;

    logic               w_tick;
    logic               w_wrap;
    logic               w_apply;
    logic               w_done;
    logic               w_done_next;

    // A counter step happens when the prescaler reaches its terminal value;
    // while one-shot has finished the counter is idle and never steps.
    assign w_tick  = en & ~w_done & (r_presc == r_act_presc);
    assign w_wrap  = w_tick & (r_count == r_act_period);
    // Apply a pending commit at the wrap edge, or immediately when idle.
    assign w_apply = r_pending & (~en | w_wrap | w_done);

`ifdef PWM_CTRL_ONESHOT_EN
    logic r_sh_mode;
    logic r_act_mode;
    logic r_done;

    // Mode bit: shadow write and commit-time copy into the active set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_mode  <= 1'b0;
            r_act_mode <= 1'b0;
        end else begin
            if (cfg_we && (cfg_addr == 3'd5)) begin
                r_sh_mode <= cfg_wdata[0];
            end
            if (w_apply) begin
                r_act_mode <= r_sh_mode;
            end
        end
    end

    // One-shot finishes at the first wrap; only en going low re-arms it.
    always_comb begin
        w_done_next = r_done;
        if (!en) begin
            w_done_next = 1'b0;
        end else if (w_wrap && r_act_mode) begin
            w_done_next = 1'b1;
        end
    end

    // Done flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
        end
    end

    assign w_done = r_done;
`else
    assign w_done_next = 1'b0;
    assign w_done      = 1'b0;
`endif

    // Shadow register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_period <= '0;
            r_sh_cmp1   <= '0;
            r_sh_cmp2   <= '0;
            r_sh_func   <= '0;
            r_sh_presc  <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                C_ADDR_PERIOD: r_sh_period <= cfg_wdata;
                C_ADDR_CMP1:   r_sh_cmp1   <= cfg_wdata;
                C_ADDR_CMP2:   r_sh_cmp2   <= cfg_wdata;
                C_ADDR_FUNC:   r_sh_func   <= cfg_wdata[7:0];
                C_ADDR_PRESC:  r_sh_presc  <= cfg_wdata[PRESC_W-1:0];
                default: ;
            endcase
        end
    end

    // Active set load from the pre-edge shadow contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_period <= '0;
            r_act_cmp1   <= '0;
            r_act_cmp2   <= '0;
            r_act_func   <= '0;
            r_act_presc  <= '0;
        end else if (w_apply) begin
            r_act_period <= r_sh_period;
            r_act_cmp1   <= r_sh_cmp1;
            r_act_cmp2   <= r_sh_cmp2;
            r_act_func   <= r_sh_func;
            r_act_presc  <= r_sh_presc;
        end
    end

    // Prescaler and period counter; stopped or finished means held at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (!en || w_done) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_count <= w_wrap ? '0 : (r_count + C_CNT_ONE);
        end else begin
            r_presc <= r_presc + C_PRESC_ONE;
        end
    end

    // Registered status: wrap pulse, comparator enable, commit pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_tick <= 1'b0;
            r_pwm_en      <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_period_tick <= w_wrap;
            r_pwm_en      <= en & ~w_done_next;
            // A commit arriving in the application cycle re-arms the request.
            r_pending     <= w_apply ? commit : (r_pending | commit);
        end
    end

    assign period_o       = r_act_period;
    assign compare1_o     = r_act_cmp1;
    assign compare2_o     = r_act_cmp2;
    assign functions_o    = r_act_func;
    assign count_val      = r_count;
    assign pwm_en_o       = r_pwm_en;
    assign period_tick    = r_period_tick;
    assign commit_pending = r_pending;
    assign done           = w_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ctrl
//  Function : Directed, table-driven checks of pwm_ctrl plus hand-written
//             multi-cycle sequences (zero period, one-shot when enabled).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ctrl;

    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_addr = '0;
    logic [CNT_W-1:0]  cfg_wdata = '0;
    logic              commit = 1'b0;
    logic [CNT_W-1:0]  period_o;
    logic [CNT_W-1:0]  compare1_o;
    logic [CNT_W-1:0]  compare2_o;
    logic [7:0]        functions_o;
    logic [CNT_W-1:0]  count_val;
    logic              pwm_en_o;
    logic              period_tick;
    logic              commit_pending;
    logic              done;

    pwm_ctrl #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .commit         (commit),
        .period_o       (period_o),
        .compare1_o     (compare1_o),
        .compare2_o     (compare2_o),
        .functions_o    (functions_o),
        .count_val      (count_val),
        .pwm_en_o       (pwm_en_o),
        .period_tick    (period_tick),
        .commit_pending (commit_pending),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wd;
        logic        commit;
        logic [15:0] cnt;
        logic        tick;
        logic        pwm;
        logic        pend;
        logic [15:0] per;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [7:0]  func;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] ep  = '0;
    logic [15:0] ec1 = '0;
    logic [15:0] ec2 = '0;
    logic [7:0]  ef  = '0;

    function automatic void add(input logic r, input logic e, input logic w,
                                input logic [2:0] a, input logic [15:0] d,
                                input logic c, input logic [15:0] cnt,
                                input logic tk, input logic pw, input logic pd);
        vec_t v;
        v.rst = r; v.en = e; v.we = w; v.addr = a; v.wd = d; v.commit = c;
        v.cnt = cnt; v.tick = tk; v.pwm = pw; v.pend = pd;
        v.per = ep; v.c1 = ec1; v.c2 = ec2; v.func = ef;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [2:0] a, input logic [15:0] d, input logic c);
        @(negedge clk);
        rst = r; en = e; cfg_we = w; cfg_addr = a; cfg_wdata = d; commit = c;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic cmp(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Table: basic count, shadowing, races, prescale, reset
        add(1,0,0,0,0,0,      0,0,0,0);
        add(0,0,1,0,4,0,      0,0,0,0);
        add(0,0,1,1,3,0,      0,0,0,0);
        add(0,0,1,3,16'hA5,0, 0,0,0,0);
        add(0,0,1,4,0,0,      0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,1);
        ep = 4; ec1 = 3; ef = 8'hA5;
        add(0,0,0,0,0,0,      0,0,0,0);
        for (int k = 1; k <= 10; k++)
            add(0,1,0,0,0,0, 16'(k % 5), (k % 5) == 0, 1, 0);
        add(0,1,1,1,7,0,      1,0,1,0);
        add(0,1,0,0,0,1,      2,0,1,1);
        add(0,1,0,0,0,0,      3,0,1,1);
        add(0,1,0,0,0,0,      4,0,1,1);
        // wrap cycle: commit re-arms, compare2 write stays in shadow
        ec1 = 7;
        add(0,1,1,2,5,1,      0,1,1,1);
        for (int k = 1; k <= 4; k++)
            add(0,1,0,0,0,0, 16'(k), 0, 1, 1);
        ec2 = 5;
        add(0,1,0,0,0,0,      0,1,1,0);
        add(0,1,0,0,0,0,      1,0,1,0);
        add(0,1,1,0,2,0,      2,0,1,0);
        add(0,1,1,4,2,0,      3,0,1,0);
        add(0,1,0,0,0,1,      4,0,1,1);
        // en drop with a pending commit: applied immediately
        ep = 2;
        add(0,0,0,0,0,0,      0,0,0,0);
        // period 2, prescale 2: each value held 3 cycles, wrap every 9
        for (int k = 0; k < 18; k++)
            add(0,1,0,0,0,0, 16'(((k + 1) / 3) % 3), ((k + 1) % 9) == 0, 1, 0);
        add(0,1,0,0,0,1,      0,0,1,1);
        add(0,1,0,0,0,0,      0,0,1,1);
        add(0,1,1,0,9,0,      1,0,1,1);
        // reset mid-period discards everything including the pending commit
        ep = 0; ec1 = 0; ec2 = 0; ef = 0;
        add(1,1,0,0,0,0,      0,0,0,0);
        add(0,0,0,0,0,0,      0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].commit);
            cmp("count_val",      i, 32'(count_val),      32'(tbl[i].cnt));
            cmp("period_tick",    i, 32'(period_tick),    32'(tbl[i].tick));
            cmp("pwm_en_o",       i, 32'(pwm_en_o),       32'(tbl[i].pwm));
            cmp("commit_pending", i, 32'(commit_pending), 32'(tbl[i].pend));
            cmp("period_o",       i, 32'(period_o),       32'(tbl[i].per));
            cmp("compare1_o",     i, 32'(compare1_o),     32'(tbl[i].c1));
            cmp("compare2_o",     i, 32'(compare2_o),     32'(tbl[i].c2));
            cmp("functions_o",    i, 32'(functions_o),    32'(tbl[i].func));
            cmp("done",           i, 32'(done),           32'h0);
        end

        // ---------------- Hand sequence: period 0 ticks on every counter step
        drive(0,0,0,0,0,1);
        cmp("p0_pend_set", 100, 32'(commit_pending), 32'h1);
        drive(0,0,0,0,0,0);
        cmp("p0_pend_clr", 101, 32'(commit_pending), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(0,1,0,0,0,0);
            cmp("p0_count", 102 + k, 32'(count_val),   32'h0);
            cmp("p0_tick",  102 + k, 32'(period_tick), 32'h1);
            cmp("p0_pwm",   102 + k, 32'(pwm_en_o),    32'h1);
        end

`ifdef PWM_CTRL_ONESHOT_EN
        // ---------------- Hand sequence: one-shot, period 3
        drive(1,0,0,0,0,0);
        drive(0,0,1,0,3,0);
        drive(0,0,1,5,1,0);
        drive(0,0,0,0,0,1);
        drive(0,0,0,0,0,0);
        cmp("os_period", 200, 32'(period_o), 32'h3);
        for (int k = 1; k <= 3; k++) begin
            drive(0,1,0,0,0,0);
            cmp("os_count", 200 + k, 32'(count_val), 32'(k));
            cmp("os_pwm",   200 + k, 32'(pwm_en_o),  32'h1);
            cmp("os_done",  200 + k, 32'(done),      32'h0);
        end
        drive(0,1,0,0,0,0);
        cmp("os_wrap_count", 204, 32'(count_val),   32'h0);
        cmp("os_wrap_tick",  204, 32'(period_tick), 32'h1);
        cmp("os_wrap_done",  204, 32'(done),        32'h1);
        cmp("os_wrap_pwm",   204, 32'(pwm_en_o),    32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0,1,0,0,0,0);
            cmp("os_hold_count", 205 + k, 32'(count_val),   32'h0);
            cmp("os_hold_tick",  205 + k, 32'(period_tick), 32'h0);
            cmp("os_hold_done",  205 + k, 32'(done),        32'h1);
            cmp("os_hold_pwm",   205 + k, 32'(pwm_en_o),    32'h0);
        end
        drive(0,0,0,0,0,0);
        cmp("os_rearm_done", 208, 32'(done), 32'h0);
        drive(0,1,0,0,0,0);
        cmp("os_restart_count", 209, 32'(count_val), 32'h1);
        cmp("os_restart_pwm",   209, 32'(pwm_en_o),  32'h1);
        cmp("os_restart_done",  209, 32'(done),      32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
